// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 VGA timing constants, the shared counter
//               width and the small types used by the VGA output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Column/row counters are this wide; 1024 covers 800 cols and 525 rows.
    localparam int unsigned c_CNT_W         = 10;

    // Standard 640x480 timing (25.175 MHz pixel clock).
    localparam int unsigned c_TOTAL_COLS    = 800;
    localparam int unsigned c_TOTAL_ROWS    = 525;
    localparam int unsigned c_ACTIVE_COLS   = 640;
    localparam int unsigned c_ACTIVE_ROWS   = 480;
    localparam int unsigned c_FRONT_PORCH_H = 16;
    localparam int unsigned c_BACK_PORCH_H  = 48;
    localparam int unsigned c_FRONT_PORCH_V = 10;
    localparam int unsigned c_BACK_PORCH_V  = 33;

    typedef logic [c_CNT_W-1:0] count_t;

    // One 12-bit RGB pixel as it travels through the pipeline.
    typedef struct packed {
        logic [3:0] red;
        logic [3:0] grn;
        logic [3:0] blu;
    } rgb_t;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_counter
// Description : Rebuilds the column/row position of an active-video style
//               sync stream. A rising edge of i_VSync marks pixel (0,0);
//               between frame starts the counters free-run and wrap at the
//               frame geometry. o_Lock rises at the first frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS = c_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS = c_TOTAL_ROWS
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_VSync,
    output logic [c_CNT_W-1:0] o_Col,
    output logic [c_CNT_W-1:0] o_Row,
    output logic               o_Lock
);

    localparam count_t c_LAST_COL = count_t'(TOTAL_COLS - 1);
    localparam count_t c_LAST_ROW = count_t'(TOTAL_ROWS - 1);
    localparam count_t c_ONE      = count_t'(1);

    logic   r_VSync_Prev;
    count_t r_Col;
    count_t r_Row;
    logic   r_Lock;
    logic   w_Frame_Start;

    // A frame begins on the first sample where VSync is high after being low.
    // r_VSync_Prev resets high so that coming out of reset in the middle of
    // an active frame (VSync already high) is not mistaken for a frame start.
    assign w_Frame_Start = i_VSync & ~r_VSync_Prev;

    // Position counters: frame start snaps to (0,0) and wins over line wrap.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_VSync_Prev <= 1'b1;
            r_Col        <= '0;
            r_Row        <= '0;
            r_Lock       <= 1'b0;
        end else begin
            r_VSync_Prev <= i_VSync;
            if (w_Frame_Start) begin
                r_Col  <= '0;
                r_Row  <= '0;
                r_Lock <= 1'b1;
            end else if (r_Col == c_LAST_COL) begin
                r_Col <= '0;
                r_Row <= (r_Row == c_LAST_ROW) ? '0 : r_Row + c_ONE;
            end else begin
                r_Col <= r_Col + c_ONE;
            end
        end
    end

    assign o_Col  = r_Col;
    assign o_Row  = r_Row;
    assign o_Lock = r_Lock;

endmodule : vga_frame_counter
`default_nettype wire

// File: rtl/vga_sync_porch.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_porch
// Description : VGA connector output stage. Converts active-video style
//               syncs into negative-polarity HSync/VSync pulses placed by the
//               porch parameters, blanks video outside the visible area and
//               delay-matches everything to a fixed 2-clock latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_porch
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS    = c_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS    = c_TOTAL_ROWS,
    parameter int unsigned ACTIVE_COLS   = c_ACTIVE_COLS,
    parameter int unsigned ACTIVE_ROWS   = c_ACTIVE_ROWS,
    parameter int unsigned FRONT_PORCH_H = c_FRONT_PORCH_H,
    parameter int unsigned BACK_PORCH_H  = c_BACK_PORCH_H,
    parameter int unsigned FRONT_PORCH_V = c_FRONT_PORCH_V,
    parameter int unsigned BACK_PORCH_V  = c_BACK_PORCH_V
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video,
    output logic       o_Locked
);

    // Sync pulse windows (inclusive) and visible-area limits, in counter units.
    localparam count_t c_HS_START  = count_t'(ACTIVE_COLS + FRONT_PORCH_H);
    localparam count_t c_HS_END    = count_t'(TOTAL_COLS - BACK_PORCH_H - 1);
    localparam count_t c_VS_START  = count_t'(ACTIVE_ROWS + FRONT_PORCH_V);
    localparam count_t c_VS_END    = count_t'(TOTAL_ROWS - BACK_PORCH_V - 1);
    localparam count_t c_ACT_COLS  = count_t'(ACTIVE_COLS);
    localparam count_t c_ACT_ROWS  = count_t'(ACTIVE_ROWS);

    count_t r_Col;
    count_t r_Row;
    logic   w_Lock;
    rgb_t   r1_Video;
    logic   w_HSync_Pulse;
    logic   w_VSync_Pulse;
    logic   w_Visible;
    logic   w_unused_hsync;

    // The column counter reconstructs everything the input HSync carries,
    // so the input HSync is intentionally not consumed.
    assign w_unused_hsync = i_HSync;

    // Stage 1: position recovery from the input vertical sync.
    vga_frame_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_frame_counter (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_VSync (i_VSync),
        .o_Col   (r_Col),
        .o_Row   (r_Row),
        .o_Lock  (w_Lock)
    );

    // Stage 1: register the pixel alongside the counters so they stay aligned.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r1_Video <= '0;
        end else begin
            r1_Video <= '{red: i_Red_Video, grn: i_Grn_Video, blu: i_Blu_Video};
        end
    end

    // Pulse and visibility decode from the stage-1 position; nothing is shown
    // or pulsed until the position has been anchored by a frame start.
    assign w_HSync_Pulse = w_Lock && (r_Col >= c_HS_START) && (r_Col <= c_HS_END);
    assign w_VSync_Pulse = w_Lock && (r_Row >= c_VS_START) && (r_Row <= c_VS_END);
    assign w_Visible     = w_Lock && (r_Col < c_ACT_COLS) && (r_Row < c_ACT_ROWS);

    // Stage 2: registered connector outputs, active-low syncs, blanked video.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_HSync     <= 1'b1;
            o_VSync     <= 1'b1;
            o_Red_Video <= 4'h0;
            o_Grn_Video <= 4'h0;
            o_Blu_Video <= 4'h0;
            o_Locked    <= 1'b0;
        end else begin
            o_HSync     <= ~w_HSync_Pulse;
            o_VSync     <= ~w_VSync_Pulse;
            o_Red_Video <= w_Visible ? r1_Video.red : 4'h0;
            o_Grn_Video <= w_Visible ? r1_Video.grn : 4'h0;
            o_Blu_Video <= w_Visible ? r1_Video.blu : 4'h0;
            o_Locked    <= w_Lock;
        end
    end

endmodule : vga_sync_porch
`default_nettype wire

// File: tb/tb_vga_sync_porch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_porch
// Description : Scoreboard bench. Instance A uses a small frame geometry and
//               sees resets, injected frame starts, held VSync and random
//               glitches; instance B uses the default 640x480 timing with an
//               ideal upstream. Expected outputs come from a linear-position
//               frame model and are compared by a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_porch;

    typedef struct packed {
        int tc; int tr; int ac; int ar; int fph; int bph; int fpv; int bpv;
    } geo_t;

    // Model state: position is a single index into the frame (col + row*tc).
    typedef struct packed {
        int         pos;
        bit         prev;
        bit         lock;
        logic [11:0] vid;
    } mstate_t;

    localparam geo_t GA = '{tc: 40, tr: 20, ac: 24, ar: 12, fph: 4, bph: 6, fpv: 2, bpv: 3};
    localparam geo_t GB = '{tc: 800, tr: 525, ac: 640, ar: 480, fph: 16, bph: 48, fpv: 10, bpv: 33};
    localparam int FR_A = GA.tc * GA.tr;
    localparam int FR_B = GB.tc * GB.tr;
    localparam logic [14:0] RST_OUT = {1'b1, 1'b1, 1'b0, 12'h000};

    logic clk;
    logic rst_a, hs_a, vs_a, rst_b, hs_b, vs_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic oa_hs, oa_vs, oa_lk, ob_hs, ob_vs, ob_lk;
    logic [3:0] oa_r, oa_g, oa_b, ob_r, ob_g, ob_b;
    logic [14:0] act_a, act_b;

    assign act_a = {oa_hs, oa_vs, oa_lk, oa_r, oa_g, oa_b};
    assign act_b = {ob_hs, ob_vs, ob_lk, ob_r, ob_g, ob_b};

    vga_sync_porch #(
        .TOTAL_COLS(GA.tc), .TOTAL_ROWS(GA.tr), .ACTIVE_COLS(GA.ac), .ACTIVE_ROWS(GA.ar),
        .FRONT_PORCH_H(GA.fph), .BACK_PORCH_H(GA.bph),
        .FRONT_PORCH_V(GA.fpv), .BACK_PORCH_V(GA.bpv)
    ) u_dut_a (
        .i_Clk(clk), .i_Rst(rst_a), .i_HSync(hs_a), .i_VSync(vs_a),
        .i_Red_Video(r_a), .i_Grn_Video(g_a), .i_Blu_Video(b_a),
        .o_HSync(oa_hs), .o_VSync(oa_vs),
        .o_Red_Video(oa_r), .o_Grn_Video(oa_g), .o_Blu_Video(oa_b),
        .o_Locked(oa_lk)
    );

    vga_sync_porch u_dut_b (
        .i_Clk(clk), .i_Rst(rst_b), .i_HSync(hs_b), .i_VSync(vs_b),
        .i_Red_Video(r_b), .i_Grn_Video(g_b), .i_Blu_Video(b_b),
        .o_HSync(ob_hs), .o_VSync(ob_vs),
        .o_Red_Video(ob_r), .o_Grn_Video(ob_g), .o_Blu_Video(ob_b),
        .o_Locked(ob_lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] qa[$];
    logic [14:0] qb[$];
    int checks   = 0;
    int failures = 0;
    int run_b    = 0;

    mstate_t sa = '{pos: 0, prev: 1'b1, lock: 1'b0, vid: 12'h000};
    mstate_t sb = '{pos: 0, prev: 1'b1, lock: 1'b0, vid: 12'h000};
    int  gpos    = 0;
    int  bpos    = FR_B - 5;
    bit  hold_vs = 1'b0;
    int  vmode   = 0;

    // Output seen one clock after a sample of stage-1 state s.
    function automatic logic [14:0] exp_out(input geo_t g, input mstate_t s);
        int col, row;
        bit hs_low, vs_low, vis;
        col    = s.pos % g.tc;
        row    = s.pos / g.tc;
        hs_low = s.lock && (col >= g.ac + g.fph) && (col < g.tc - g.bph);
        vs_low = s.lock && (row >= g.ar + g.fpv) && (row < g.tr - g.bpv);
        vis    = s.lock && (col < g.ac) && (row < g.ar);
        return {~hs_low, ~vs_low, s.lock, vis ? s.vid : 12'h000};
    endfunction

    function automatic mstate_t next_state(input geo_t g, input mstate_t s, input bit rst,
                                           input bit vs, input logic [11:0] vid);
        mstate_t n;
        if (rst) begin
            n = '{pos: 0, prev: 1'b1, lock: 1'b0, vid: 12'h000};
        end else begin
            n      = s;
            n.prev = vs;
            n.vid  = vid;
            if (vs && !s.prev) begin
                n.pos  = 0;
                n.lock = 1'b1;
            end else begin
                n.pos = (s.pos + 1) % (g.tc * g.tr);
            end
        end
        return n;
    endfunction

    // One clock: drive both DUTs, predict, and queue the expected outputs.
    task automatic step(input bit ra, input bit ha, input bit va, input logic [11:0] vida,
                        input bit rb);
        logic [14:0] ea, eb;
        logic [11:0] vidb;
        bit hb, vb;
        vidb = 12'($urandom);
        hb   = (bpos % GB.tc) < GB.ac;
        vb   = (bpos / GB.tc) < GB.ar;
        rst_a = ra; hs_a = ha; vs_a = va; {r_a, g_a, b_a} = vida;
        rst_b = rb; hs_b = hb; vs_b = vb; {r_b, g_b, b_b} = vidb;
        ea = ra ? RST_OUT : exp_out(GA, sa);
        eb = rb ? RST_OUT : exp_out(GB, sb);
        sa = next_state(GA, sa, ra, va, vida);
        sb = next_state(GB, sb, rb, vb, vidb);
        bpos = (bpos + 1) % FR_B;
        @(posedge clk);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
    endtask

    // Ideal upstream for instance A.
    task automatic run_a(input int n);
        int col, row;
        logic [11:0] v;
        for (int i = 0; i < n; i++) begin
            col = gpos % GA.tc;
            row = gpos / GA.tc;
            v   = (vmode == 1) ? 12'hFFF : 12'($urandom);
            step(1'b0, col < GA.ac, hold_vs ? 1'b1 : (row < GA.ar), v, 1'b0);
            gpos = (gpos + 1) % FR_A;
        end
    endtask

    task automatic goto_a(input int col, input int row);
        run_a((row * GA.tc + col - gpos + FR_A) % FR_A);
    endtask

    // Monitor: every cycle both DUTs present an output; pop and compare.
    always @(negedge clk) begin
        logic [14:0] e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            checks++;
            if (act_a !== e) begin
                failures++;
                $display("FAIL sb_small t=%0t actual=%h required=%h", $time, act_a, e);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            checks++;
            if (act_b !== e) begin
                failures++;
                $display("FAIL sb_vga640 t=%0t actual=%h required=%h", $time, act_b, e);
            end
        end
        // Every completed HSync pulse at 640x480 timing lasts 96 clocks.
        if (ob_hs === 1'b0) begin
            run_b++;
        end else begin
            if (run_b != 0) begin
                checks++;
                if (run_b != 96) begin
                    failures++;
                    $display("FAIL hsync_width t=%0t actual=%0d required=96", $time, run_b);
                end
            end
            run_b = 0;
        end
    end

    initial begin
        bit ra, va;
        // Reset with random inputs on both instances.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 12'($urandom), 1'b1);
        end
        // Start A in vertical blanking so the first VSync rise is a real edge.
        gpos = GA.tc * GA.ar + 3;
        run_a(3 * FR_A);
        // Full-white input: only the visible area may show it.
        vmode = 1;
        run_a(FR_A);
        vmode = 0;
        // Injected frame start in the middle of the active area.
        goto_a(10, 5);
        step(1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0);
        gpos = 0;
        run_a(2 * FR_A);
        // One-cycle reset mid-frame with VSync already high at release.
        goto_a(30, 8);
        step(1'b1, 1'b0, 1'b1, 12'($urandom), 1'b0);
        gpos = (gpos + 1) % FR_A;
        run_a(2 * FR_A);
        // VSync held high: counters must free-run and keep pulsing.
        hold_vs = 1'b1;
        run_a(2 * FR_A);
        hold_vs = 1'b0;
        run_a(FR_A);
        // Random VSync glitches and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 299) == 0);
            va = ((gpos / GA.tc) < GA.ar) ^ ($urandom_range(0, 49) == 0);
            step(ra, (gpos % GA.tc) < GA.ac, va, 12'($urandom), 1'b0);
            gpos = (gpos + 1) % FR_A;
        end
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", qa.size() + qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vga_sync_porch
`default_nettype wire
